sdram_init_ctrl: RTL and testbench



---
 rtl/sdram_pkg.sv | 40 ++++
 rtl/sdram_init_timer.sv | 28 ++
 rtl/sdram_init_ctrl.sv | 157 +++++++++++++++
 tb/tb_sdram_init_ctrl.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/sdram_pkg.sv
// Shared definitions for the SDRAM init sequencer: command encodings, FSM states
// and the mode-register field layout.
package sdram_pkg;

  localparam logic [3:0] CMD_NOP  = 4'b0111;
  localparam logic [3:0] CMD_PREC = 4'b0010;
  localparam logic [3:0] CMD_AREF = 4'b0001;
  localparam logic [3:0] CMD_MRS  = 4'b0000;

  typedef enum logic [3:0] {
    ST_WAIT,
    ST_PRE,
    ST_TRP,
    ST_AREF,
    ST_TRFC,
    ST_MRS,
    ST_TMRD,
    ST_EMRS,
    ST_TEMRD,
    ST_DONE
  } state_t;

  localparam int MR_BL  = 0;
  localparam int MR_BT  = 3;
  localparam int MR_CAS = 4;
  localparam int MR_WB  = 9;
  localparam int MODE_W = 10;

  // Bits above A9 are always zero; the caller zero-extends to the row width.
  function automatic logic [MODE_W-1:0] build_mode(input logic [2:0] cas, input logic [2:0] bl);
    logic [MODE_W-1:0] m;
    m              = '0;
    m[MR_BL +: 3]  = bl;
    m[MR_BT]       = 1'b0;
    m[MR_CAS +: 3] = cas;
    m[MR_WB]       = 1'b0;
    return m;
  endfunction

endpackage

// File: rtl/sdram_init_timer.sv
// Loadable saturating down-counter; done is high while the count is zero.
// Load value L gives done on the (L+1)-th cycle after the load edge.
module sdram_init_timer #(
  parameter int           W       = 8,
  parameter logic [W-1:0] RST_VAL = '0
) (
  input  logic         clk,
  input  logic         rstn,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         done
);

  logic [W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      cnt <= RST_VAL;
    end else if (load) begin
      cnt <= load_val;
    end else if (cnt != '0) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign done = (cnt == '0);

endmodule

// File: rtl/sdram_init_ctrl.sv
// SDRAM power-up init sequencer with run-time mode-register reload; drives the command bus until init_end.
// Define SDRAM_INIT_EMRS_EN to add an extended-mode-register write after MRS (mobile/low-power parts).
module sdram_init_ctrl
  import sdram_pkg::*;
#(
  parameter int         T_WAIT_CYC = 20000,
  parameter int         TRP_CYC    = 2,
  parameter int         TRFC_CYC   = 7,
  parameter int         TMRD_CYC   = 3,
  parameter int         AREF_NUM   = 8,
  parameter int         ROW_W      = 13,
  parameter int         BANK_W     = 2,
  parameter int         CAS_DEF    = 3,
  parameter logic [2:0] BL_DEF     = 3'b111
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              reinit_req,
  input  logic [2:0]        cfg_cas,
  input  logic [2:0]        cfg_bl,
  output logic              reinit_ack,
  output logic              cfg_err,
  output logic [3:0]        init_cmd,
  output logic [BANK_W-1:0] init_bank,
  output logic [ROW_W-1:0]  init_addr,
  output logic              init_end
);

  localparam int SPC_A   = (TRP_CYC > TRFC_CYC) ? TRP_CYC : TRFC_CYC;
  localparam int SPC_MAX = (SPC_A > TMRD_CYC) ? SPC_A : TMRD_CYC;
  localparam int CNT_MAX = (T_WAIT_CYC > SPC_MAX) ? T_WAIT_CYC : SPC_MAX;
  localparam int TW      = $clog2(CNT_MAX + 1);
  localparam int RW      = $clog2(AREF_NUM + 1);
  // A state holding for X cycles leaves X-1 edges after entry; the registered
  // command adds the last cycle, hence the "-2" loads.
  localparam logic [TW-1:0] WAIT_LOAD = TW'(T_WAIT_CYC - 2);

  state_t             state, state_n;
  logic [2:0]         mode_cas, mode_bl;
  logic [RW-1:0]      ref_cnt;
  logic               tmr_load, tmr_done, accept, cas_ok;
  logic [TW-1:0]      tmr_val;
  logic [3:0]         cmd_n;
  logic [BANK_W-1:0]  bank_n;
  logic [ROW_W-1:0]   addr_n;

  assign cas_ok   = (cfg_cas == 3'd2) || (cfg_cas == 3'd3);
  assign tmr_load = (state_n != state);

  sdram_init_timer #(
    .W       (TW),
    .RST_VAL (WAIT_LOAD)
  ) u_timer (
    .clk      (clk),
    .rstn     (rstn),
    .load     (tmr_load),
    .load_val (tmr_val),
    .done     (tmr_done)
  );

  always_ff @(posedge clk) begin
    if (!rstn) state <= ST_WAIT;
    else       state <= state_n;
  end

  always_comb begin
    state_n = state;
    accept  = 1'b0;
    cmd_n   = CMD_NOP;
    bank_n  = '1;
    addr_n  = '1;
    case (state)
      ST_WAIT: if (tmr_done) state_n = ST_PRE;
      ST_PRE: begin
        cmd_n      = CMD_PREC;
        bank_n     = '0;
        addr_n     = '0;
        addr_n[10] = 1'b1;
        state_n    = ST_TRP;
      end
      ST_TRP: if (tmr_done) state_n = ST_AREF;
      ST_AREF: begin
        cmd_n   = CMD_AREF;
        state_n = ST_TRFC;
      end
      ST_TRFC: if (tmr_done) state_n = (ref_cnt == RW'(AREF_NUM)) ? ST_MRS : ST_AREF;
      ST_MRS: begin
        cmd_n   = CMD_MRS;
        bank_n  = '0;
        addr_n  = {{(ROW_W - MODE_W){1'b0}}, build_mode(mode_cas, mode_bl)};
        state_n = ST_TMRD;
      end
`ifdef SDRAM_INIT_EMRS_EN
      ST_TMRD: if (tmr_done) state_n = ST_EMRS;
      ST_EMRS: begin
        cmd_n   = CMD_MRS;
        bank_n  = BANK_W'(2);
        addr_n  = '0;
        state_n = ST_TEMRD;
      end
      ST_TEMRD: if (tmr_done) state_n = ST_DONE;
`else
      ST_TMRD: if (tmr_done) state_n = ST_DONE;
`endif
      // init_end being high guarantees the controller has announced completion.
      ST_DONE: if (init_end && reinit_req) begin
        accept  = 1'b1;
        state_n = ST_PRE;
      end
      default: state_n = ST_WAIT;
    endcase
  end

  always_comb begin
    tmr_val = '0;
    case (state_n)
      ST_TRP:             tmr_val = TW'(TRP_CYC - 2);
      ST_TRFC:            tmr_val = TW'(TRFC_CYC - 2);
      ST_TMRD, ST_TEMRD:  tmr_val = TW'(TMRD_CYC - 2);
      default:            tmr_val = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      mode_cas <= 3'(CAS_DEF);
      mode_bl  <= BL_DEF;
      ref_cnt  <= '0;
    end else begin
      if (accept) begin
        mode_bl  <= cfg_bl;
        mode_cas <= cas_ok ? cfg_cas : 3'(CAS_DEF);
      end
      if (state_n == ST_PRE && state != ST_PRE) ref_cnt <= '0;
      else if (state == ST_AREF)                ref_cnt <= ref_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      init_cmd   <= CMD_NOP;
      init_bank  <= '1;
      init_addr  <= '1;
      init_end   <= 1'b0;
      reinit_ack <= 1'b0;
      cfg_err    <= 1'b0;
    end else begin
      init_cmd   <= cmd_n;
      init_bank  <= bank_n;
      init_addr  <= addr_n;
      init_end   <= (state == ST_DONE) && !accept;
      reinit_ack <= accept;
      cfg_err    <= accept && !cas_ok;
    end
  end

endmodule

// File: tb/tb_sdram_init_ctrl.sv
// Bench for sdram_init_ctrl: a small-parameter instance checked every cycle against a
// schedule model, plus a default-parameter instance checked for the power-up timeline.
module tb_sdram_init_ctrl;

  localparam int TW = 10, TRP = 2, TRFC = 4, TMRD = 3, NREF = 2;
  localparam int ROW_W = 13, BANK_W = 2, CASD = 3;
  localparam logic [2:0] BLD = 3'b111;
`ifdef SDRAM_INIT_EMRS_EN
  localparam int EMRS_ON = 1;
`else
  localparam int EMRS_ON = 0;
`endif
  localparam logic [3:0] C_NOP = 4'b0111, C_PREC = 4'b0010, C_AREF = 4'b0001, C_MRS = 4'b0000;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rstn, reinit_req, reinit_ack, cfg_err, init_end;
  logic [2:0]        cfg_cas, cfg_bl;
  logic [3:0]        init_cmd;
  logic [BANK_W-1:0] init_bank;
  logic [ROW_W-1:0]  init_addr;

  logic              rstn_def, d_ack, d_err, d_end;
  logic [3:0]        d_cmd;
  logic [1:0]        d_bank;
  logic [12:0]       d_addr;

  sdram_init_ctrl #(
    .T_WAIT_CYC(TW), .TRP_CYC(TRP), .TRFC_CYC(TRFC), .TMRD_CYC(TMRD), .AREF_NUM(NREF),
    .ROW_W(ROW_W), .BANK_W(BANK_W), .CAS_DEF(CASD), .BL_DEF(BLD)
  ) dut (
    .clk(clk), .rstn(rstn), .reinit_req(reinit_req), .cfg_cas(cfg_cas), .cfg_bl(cfg_bl),
    .reinit_ack(reinit_ack), .cfg_err(cfg_err), .init_cmd(init_cmd), .init_bank(init_bank),
    .init_addr(init_addr), .init_end(init_end)
  );

  sdram_init_ctrl dut_def (
    .clk(clk), .rstn(rstn_def), .reinit_req(1'b0), .cfg_cas(3'd0), .cfg_bl(3'd0),
    .reinit_ack(d_ack), .cfg_err(d_err), .init_cmd(d_cmd), .init_bank(d_bank),
    .init_addr(d_addr), .init_end(d_end)
  );

  int n_chk = 0, n_err = 0;
  int t = 0;

  // Schedule model: P = PRE cycle, M = MRS cycle, E = init_end rise, A = last accept cycle.
  int         m_P = 1 << 30, m_M = 1 << 30, m_E = 1 << 30, m_A = -1;
  logic       m_err = 1'b0;
  logic [2:0] m_cas = 3'(CASD), m_bl = BLD;

  logic [ROW_W-1:0] mrs_addr_seen;
  int pre_t = -1, ack_t = -1;

  task automatic chk(input string name, input longint got, input longint want);
    n_chk++;
    if (got != want) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", name, got, want);
    end
  endtask

  task automatic sched(input int p);
    m_P = p;
    m_M = p + TRP + NREF * TRFC;
    m_E = m_M + TMRD * (1 + EMRS_ON);
  endtask

  task automatic model_edge(input logic rs, input logic rq, input logic [2:0] cs, input logic [2:0] b);
    int te;
    te = t + 1;
    if (!rs) begin
      m_cas = 3'(CASD);
      m_bl  = BLD;
      m_A   = -1;
      sched(te + TW);
    end else if (rq && t >= m_E) begin
      m_A   = te;
      m_err = !(cs == 3'd2 || cs == 3'd3);
      m_cas = m_err ? 3'(CASD) : cs;
      m_bl  = b;
      sched(te + 1);
    end
  endtask

  task automatic check_cycle();
    logic [3:0]        ec;
    logic [BANK_W-1:0] eb;
    logic [ROW_W-1:0]  ea;
    logic              chk_ba, e_end, e_ack, e_e, ok;
    ec = C_NOP; eb = '1; ea = '1; chk_ba = 1'b1;
    if (t == m_P) begin
      ec = C_PREC; eb = '0; ea = ROW_W'(1 << 10);
    end else if (t >= m_P + TRP && t < m_M && ((t - m_P - TRP) % TRFC) == 0) begin
      ec = C_AREF; chk_ba = 1'b0;
    end else if (t == m_M) begin
      ec = C_MRS; eb = '0; ea = ROW_W'(int'(m_cas) * 16 + int'(m_bl));
    end else if (EMRS_ON != 0 && t == m_M + TMRD) begin
      ec = C_MRS; eb = BANK_W'(2); ea = '0;
    end
    e_end = (t >= m_E);
    e_ack = (t == m_A);
    e_e   = e_ack && m_err;
    ok = (init_cmd === ec) && (!chk_ba || (init_bank === eb && init_addr === ea)) &&
         (init_end === e_end) && (reinit_ack === e_ack) && (cfg_err === e_e);
    n_chk++;
    if (!ok) begin
      n_err++;
      $display("FAIL cycle %0d: got cmd=%b bank=%b addr=%h end=%b ack=%b err=%b, expected cmd=%b bank=%b addr=%h end=%b ack=%b err=%b",
               t, init_cmd, init_bank, init_addr, init_end, reinit_ack, cfg_err, ec, eb, ea, e_end, e_ack, e_e);
    end
  endtask

  task automatic step(input logic rs, input logic rq, input logic [2:0] cs, input logic [2:0] b);
    rstn = rs; reinit_req = rq; cfg_cas = cs; cfg_bl = b;
    model_edge(rs, rq, cs, b);
    @(posedge clk);
    t = t + 1;
    @(negedge clk);
    check_cycle();
    if (init_cmd === C_MRS && init_bank === '0) mrs_addr_seen = init_addr;
    if (init_cmd === C_PREC && pre_t < 0) pre_t = t;
    if (reinit_ack === 1'b1) ack_t = t;
  endtask

  task automatic run_to_done();
    for (int k = 0; k < 400 && t < m_E; k++) step(1'b1, 1'b0, 3'($urandom), 3'($urandom));
  endtask

  // Default-parameter instance: log every non-NOP command relative to its reset edge (cycle 1).
  int         d_cyc[$];
  logic [3:0] d_cmdq[$];
  logic [1:0] d_bankq[$];
  logic [12:0] d_addrq[$];
  int         d_end_t = -1;
  logic       d_spur = 1'b0;
  always @(negedge clk) begin
    if (t >= 2) begin
      if (d_cmd !== C_NOP) begin
        d_cyc.push_back(t - 1); d_cmdq.push_back(d_cmd);
        d_bankq.push_back(d_bank); d_addrq.push_back(d_addr);
      end
      if (d_end === 1'b1 && d_end_t < 0) d_end_t = t - 1;
      if (d_ack === 1'b1 || d_err === 1'b1) d_spur = 1'b1;
    end
  end

  typedef struct {
    logic [2:0]       cas;
    logic [2:0]       bl;
    logic             exp_err;
    logic [ROW_W-1:0] exp_addr;
  } vec_t;
  vec_t vecs[6];

  initial begin
    logic req;
    int   r_edge, n_exp, ec_t;
    logic [3:0] ec;

    vecs[0] = '{3'd2, 3'b011, 1'b0, 13'h0023};
    vecs[1] = '{3'd5, 3'b010, 1'b1, 13'h0032};
    vecs[2] = '{3'd3, 3'b111, 1'b0, 13'h0037};
    vecs[3] = '{3'd0, 3'b001, 1'b1, 13'h0031};
    vecs[4] = '{3'd7, 3'b000, 1'b1, 13'h0030};
    vecs[5] = '{3'd2, 3'b111, 1'b0, 13'h0027};

    rstn_def = 1'b0;
    step(1'b0, 1'b0, 3'd0, 3'd0);
    rstn_def = 1'b1;
    chk("reset_cmd", init_cmd, C_NOP);
    chk("reset_addr", init_addr, 13'h1fff);
    chk("reset_end", init_end, 0);

    mrs_addr_seen = '1;
    run_to_done();
    chk("powerup_mrs_addr", mrs_addr_seen, 13'h0037);

    for (int i = 0; i < 6; i++) begin
      mrs_addr_seen = '1;
      step(1'b1, 1'b1, vecs[i].cas, vecs[i].bl);
      chk($sformatf("vec%0d_ack", i), reinit_ack, 1);
      chk($sformatf("vec%0d_err", i), cfg_err, vecs[i].exp_err);
      chk($sformatf("vec%0d_end_fall", i), init_end, 0);
      run_to_done();
      chk($sformatf("vec%0d_mrs_addr", i), mrs_addr_seen, vecs[i].exp_addr);
    end

    // Reset in the middle of TRFC with a re-init request held throughout.
    step(1'b1, 1'b1, 3'd3, 3'b111);
    while (t < m_P + TRP + 1) step(1'b1, 1'b0, 3'd0, 3'd0);
    pre_t = -1; ack_t = -1;
    step(1'b0, 1'b1, 3'd2, 3'b001);
    r_edge = t;
    chk("midrst_cmd", init_cmd, C_NOP);
    chk("midrst_bank", init_bank, 2'b11);
    for (int k = 0; k < 100 && ack_t < 0; k++) step(1'b1, 1'b1, 3'd2, 3'b001);
    chk("midrst_pre_delay", pre_t - r_edge, TW);
    chk("midrst_ack_delay", ack_t - r_edge, TW + TRP + NREF * TRFC + TMRD * (1 + EMRS_ON) + 1);
    run_to_done();

    req = 1'b0;
    for (int k = 0; k < 1500; k++) begin
      if (!req) req = ($urandom_range(0, 7) == 0);
      step(($urandom_range(0, 399) != 0), req, 3'($urandom), 3'($urandom));
      if (reinit_ack === 1'b1) req = 1'b0;
    end

    while (t < 20075) step(1'b1, 1'b0, 3'd0, 3'd0);

    n_exp = 10 + EMRS_ON;
    chk("def_cmd_count", d_cyc.size(), n_exp);
    for (int i = 0; i < d_cyc.size() && i < n_exp; i++) begin
      if (i == 0) begin ec_t = 20000; ec = C_PREC; end
      else if (i <= 8) begin ec_t = 20002 + 7 * (i - 1); ec = C_AREF; end
      else if (i == 9) begin ec_t = 20058; ec = C_MRS; end
      else begin ec_t = 20061; ec = C_MRS; end
      chk($sformatf("def_cmd%0d_cycle", i), d_cyc[i], ec_t);
      chk($sformatf("def_cmd%0d_code", i), d_cmdq[i], ec);
    end
    if (d_cyc.size() > 9) begin
      chk("def_mrs_addr", d_addrq[9], 13'h0037);
      chk("def_mrs_bank", d_bankq[9], 0);
      chk("def_pre_a10", d_addrq[0][10], 1);
    end
`ifdef SDRAM_INIT_EMRS_EN
    if (d_cyc.size() > 10) begin
      chk("def_emrs_bank", d_bankq[10], 2);
      chk("def_emrs_addr", d_addrq[10], 0);
    end
`endif
    chk("def_end_rise", d_end_t, 20061 + 3 * EMRS_ON);
    chk("def_no_ack", d_spur, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
